// File: rtl/uart_cipher_bridge_pkg.sv
// Shared state encoding, word geometry and byte-ordering helper for the UART/cipher bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } bridge_state_t;

    localparam int DBITS      = 8;
    localparam int KEY_BYTES  = 16;
    localparam int TXT_BYTES  = 16;
    localparam int KEY_BITS   = DBITS * KEY_BYTES;
    localparam int TXT_BITS   = DBITS * TXT_BYTES;
    localparam int WORD_BYTES = KEY_BYTES + TXT_BYTES;
    localparam int WORD_BITS  = KEY_BITS + TXT_BITS;

    // Returns the Rx word with the first received byte in the top byte lane.
    function automatic logic [WORD_BITS-1:0] arrival_order(input logic [WORD_BITS-1:0] word,
                                                           input logic first_msb);
        logic [WORD_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            r[WORD_BITS-1-DBITS*i -: DBITS] = first_msb ? word[WORD_BITS-1-DBITS*i -: DBITS]
                                                        : word[DBITS*i +: DBITS];
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_cipher_bridge_if.sv
// Bus bundle between the bridge (slave) and the UART/cipher cores around it (master).
interface uart_cipher_bridge_if;
    import uart_bridge_pkg::*;

    // Strobes, no back-pressure: rx_full rising edge offers read_data; cipher_start and
    // tx_load are single-cycle pulses qualifying key_out/pt_out and write_data respectively;
    // cipher_done qualifies ct_in and is only honoured while the bridge is in WAIT.
    logic                 rx_full;
    logic [WORD_BITS-1:0] read_data;
    logic [KEY_BITS-1:0]  key_out;
    logic [TXT_BITS-1:0]  pt_out;
    logic                 cipher_start;
    logic                 cipher_done;
    logic [TXT_BITS-1:0]  ct_in;
    logic [TXT_BITS-1:0]  write_data;
    logic                 tx_load;
    logic                 busy;
    logic                 overrun;
    logic                 timeout;
    bridge_state_t        state;

    modport slave (
        input  rx_full, read_data, cipher_done, ct_in,
        output key_out, pt_out, cipher_start, write_data, tx_load, busy, overrun, timeout, state
    );

    modport master (
        output rx_full, read_data, cipher_done, ct_in,
        input  key_out, pt_out, cipher_start, write_data, tx_load, busy, overrun, timeout, state
    );

endinterface

// File: rtl/uart_cipher_bridge_rise_detect.sv
// Rising-edge detector for the Rx FIFO full flag.
module rise_detect (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/uart_cipher_bridge.sv
// Captures key/plaintext from the UART Rx word, launches the cipher and hands the result to Tx.
// Optional cipher watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module uart_cipher_bridge
    import uart_bridge_pkg::*;
#(
    parameter bit FIRST_MSB = 1'b1
`ifdef BRIDGE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1_000_000
`endif
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    uart_cipher_bridge_if.slave  bus
);

    logic                 rise;
    logic                 expire;
    logic [WORD_BITS-1:0] ordered;
    bridge_state_t        state;
    logic [KEY_BITS-1:0]  key_r;
    logic [TXT_BITS-1:0]  pt_r;
    logic [TXT_BITS-1:0]  wdata_r;
    logic                 start_r;
    logic                 load_r;
    logic                 busy_r;
    logic                 overrun_r;

    rise_detect u_rise (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .d          (bus.rx_full),
        .rise       (rise)
    );

    assign ordered = arrival_order(bus.read_data, FIRST_MSB);

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wd_cnt;
    logic          timeout_r;

    assign expire = (wd_cnt == LAST);

    // Counter restarts while in START so the first WAIT cycle counts as zero.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state == START)     wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (state == WAIT && !bus.cipher_done && expire) timeout_r <= 1'b1;
        end
    end

    assign bus.timeout = timeout_r;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            key_r     <= '0;
            pt_r      <= '0;
            wdata_r   <= '0;
            start_r   <= 1'b0;
            load_r    <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            start_r <= 1'b0;
            load_r  <= 1'b0;
            // A word arriving anywhere but IDLE, including the EMIT exit cycle, is lost.
            if (rise && state != IDLE) overrun_r <= 1'b1;
            case (state)
                IDLE: begin
                    if (rise) begin
                        key_r   <= ordered[WORD_BITS-1 -: KEY_BITS];
                        pt_r    <= ordered[TXT_BITS-1:0];
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (bus.cipher_done) begin
                        wdata_r <= bus.ct_in;
                        load_r  <= 1'b1;
                        state   <= EMIT;
                    end else if (expire) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                EMIT: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.key_out      = key_r;
    assign bus.pt_out       = pt_r;
    assign bus.write_data   = wdata_r;
    assign bus.cipher_start = start_r;
    assign bus.tx_load      = load_r;
    assign bus.busy         = busy_r;
    assign bus.overrun      = overrun_r;
    assign bus.state        = state;

endmodule

// File: tb/tb_uart_cipher_bridge.sv
// Scoreboard bench for uart_cipher_bridge: directed words, expected launches/results queued.
module tb_uart_cipher_bridge;
    import uart_bridge_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_100MHz = 1'b0;
    logic reset      = 1'b1;
    always #5 clk_100MHz = ~clk_100MHz;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    uart_cipher_bridge_if bus ();
    uart_cipher_bridge_if bus_lsb ();

    uart_cipher_bridge #(
        .FIRST_MSB (1'b1)
`ifdef BRIDGE_TIMEOUT_EN
        , .TIMEOUT_CYC (100)
`endif
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus)
    );

    uart_cipher_bridge #(
        .FIRST_MSB (1'b0)
`ifdef BRIDGE_TIMEOUT_EN
        , .TIMEOUT_CYC (100)
`endif
    ) dut_lsb (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus_lsb)
    );

    // ---------------- scoreboard ----------------
    int n_cmp   = 0;
    int n_bad   = 0;
    int n_start = 0;
    int n_load  = 0;

    logic [WORD_BITS-1:0] exp_start_q[$];
    int                   exp_start_cyc_q[$];
    logic [TXT_BITS-1:0]  exp_load_q[$];
    int                   exp_load_cyc_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_100MHz) begin
        if (bus.cipher_start) begin
            n_start++;
            if (exp_start_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL start_unexpected: cipher_start at cycle %0d, expected none", cyc);
            end else begin
                check("start_key_pt", {bus.key_out, bus.pt_out}, exp_start_q.pop_front());
                check("start_cycle", cyc, exp_start_cyc_q.pop_front());
            end
        end
        if (bus.tx_load) begin
            n_load++;
            if (exp_load_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL load_unexpected: tx_load at cycle %0d, expected none", cyc);
            end else begin
                check("load_data", bus.write_data, exp_load_q.pop_front());
                check("load_cycle", cyc, exp_load_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    function automatic logic [255:0] seq_word(input logic [7:0] base);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[255-8*i -: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic send(input logic [255:0] w, input bit expect_capture);
        bus.read_data = w;
        bus.rx_full   = 1'b1;
        if (expect_capture) begin
            exp_start_q.push_back(w);
            exp_start_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic drop();
        bus.rx_full = 1'b0;
    endtask

    task automatic finish_cipher(input logic [127:0] ct, input bit expect_load);
        bus.ct_in       = ct;
        bus.cipher_done = 1'b1;
        if (expect_load) begin
            exp_load_q.push_back(ct);
            exp_load_cyc_q.push_back(cyc + 1);
        end
        tick(1);
        bus.cipher_done = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] w1;
        logic [255:0] w3;
        logic [255:0] w4;
        logic [255:0] d;
        logic [127:0] ct4;
        int s0;
        int l0;

        bus.rx_full = 1'b0;     bus.read_data = '0;     bus.cipher_done = 1'b0;     bus.ct_in = '0;
        bus_lsb.rx_full = 1'b0; bus_lsb.read_data = '0; bus_lsb.cipher_done = 1'b0; bus_lsb.ct_in = '0;
        ct4 = {16{8'h3C}};

        reset = 1'b1;
        tick(3);
        check("rst_busy", bus.busy, 0);
        check("rst_state", bus.state, IDLE);
        check("rst_key", bus.key_out, 0);
        check("rst_pt", bus.pt_out, 0);
        check("rst_wdata", bus.write_data, 0);
        check("rst_strobes", {bus.cipher_start, bus.tx_load}, 0);
        check("rst_flags", {bus.overrun, bus.timeout}, 0);
        reset = 1'b0;
        tick(2);

        // Reset while waiting on the cipher aborts the transaction.
        send(seq_word(8'h40), 1'b1);
        tick(1);
        drop();
        tick(3);
        check("t1_in_wait", bus.state, WAIT);
        check("t1_busy_before", bus.busy, 1);
        reset = 1'b1;
        tick(1);
        check("t1_busy_after", bus.busy, 0);
        check("t1_state_after", bus.state, IDLE);
        bus.cipher_done = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        bus.cipher_done = 1'b0;
        tick(8);
        check("t1_start_count", n_start, 1);
        check("t1_load_count", n_load, 0);
        check("t1_key_cleared", bus.key_out, 0);

        // Basic transaction: done 10 cycles after the rise.
        s0 = n_start;
        l0 = n_load;
        send(seq_word(8'h00), 1'b1);
        tick(1);
        drop();
        check("t2_key", bus.key_out, 128'h000102030405060708090A0B0C0D0E0F);
        check("t2_pt", bus.pt_out, 128'h101112131415161718191A1B1C1D1E1F);
        check("t2_start_hi", bus.cipher_start, 1);
        tick(9);
        finish_cipher({16{8'hA5}}, 1'b1);
        check("t2_tx_load_hi", bus.tx_load, 1);
        check("t2_wdata", bus.write_data, {16{8'hA5}});
        tick(1);
        check("t2_tx_load_lo", bus.tx_load, 0);
        check("t2_idle", bus.busy, 0);
        tick(5);
        check("t2_wdata_held", bus.write_data, {16{8'hA5}});
        check("t2_one_load", n_load - l0, 1);
        check("t2_one_start", n_start - s0, 1);

        // Overrun in WAIT, then a rise coinciding with the EMIT exit.
        s0 = n_start;
        l0 = n_load;
        w1 = seq_word(8'h20);
        send(w1, 1'b1);
        tick(1);
        drop();
        tick(3);
        check("t3_no_overrun_yet", bus.overrun, 0);
        send(seq_word(8'h80), 1'b0);
        tick(1);
        drop();
        tick(1);
        check("t3_overrun", bus.overrun, 1);
        check("t3_key_kept", bus.key_out, w1[255:128]);
        check("t3_still_wait", bus.state, WAIT);
        finish_cipher({16{8'h5A}}, 1'b1);
        send(seq_word(8'hC0), 1'b0);
        tick(1);
        drop();
        tick(3);
        check("t3_emit_rise_dropped", bus.busy, 0);
        check("t3_key_after_emit", bus.key_out, w1[255:128]);
        check("t3_one_load", n_load - l0, 1);
        check("t3_one_start", n_start - s0, 1);

        // rx_full held high across a full transaction, then re-armed.
        s0 = n_start;
        l0 = n_load;
        w3 = seq_word(8'h60);
        send(w3, 1'b1);
        tick(10);
        finish_cipher({16{8'hC3}}, 1'b1);
        tick(38);
        check("t4_level_one_start", n_start - s0, 1);
        check("t4_level_idle", bus.busy, 0);
        drop();
        tick(1);
        w4 = seq_word(8'h70);
        send(w4, 1'b1);
        tick(1);
        drop();
        tick(3);
        finish_cipher(ct4, 1'b1);
        tick(3);
        check("t4_two_starts", n_start - s0, 2);
        check("t4_two_loads", n_load - l0, 2);
        check("t4_wdata", bus.write_data, ct4);

        // First received byte in read_data[7:0].
        for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(i);
        d[7:0] = 8'hAB;
        bus_lsb.read_data = d;
        bus_lsb.rx_full   = 1'b1;
        tick(1);
        bus_lsb.rx_full   = 1'b0;
        check("t5_key_top_byte", bus_lsb.key_out[127:120], 8'hAB);
        check("t5_key", bus_lsb.key_out, 128'hAB0102030405060708090A0B0C0D0E0F);
        check("t5_pt", bus_lsb.pt_out, 128'h101112131415161718191A1B1C1D1E1F);
        check("t5_start", bus_lsb.cipher_start, 1);
        tick(2);

`ifdef BRIDGE_TIMEOUT_EN
        // Watchdog expiry without done, then done landing on the expiry cycle.
        l0 = n_load;
        send(seq_word(8'h90), 1'b1);
        tick(1);
        drop();
        tick(100);
        check("t6_wait_last", bus.state, WAIT);
        check("t6_timeout_not_yet", bus.timeout, 0);
        tick(1);
        check("t6_idle", bus.busy, 0);
        check("t6_timeout", bus.timeout, 1);
        check("t6_wdata_kept", bus.write_data, ct4);
        tick(3);
        check("t6_no_load", n_load - l0, 0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("t6_timeout_cleared", bus.timeout, 0);
        send(seq_word(8'hA0), 1'b1);
        tick(1);
        drop();
        tick(100);
        finish_cipher({16{8'h96}}, 1'b1);
        check("t6_done_wins_load", bus.tx_load, 1);
        check("t6_done_wins_flag", bus.timeout, 0);
        tick(2);
        check("t6_final_idle", bus.busy, 0);
`else
        tick(200);
        check("t6_lsb_waits", bus_lsb.state, WAIT);
        check("t6_timeout_tied", {bus.timeout, bus_lsb.timeout}, 0);
`endif

        tick(2);
        check("start_queue_drained", exp_start_q.size(), 0);
        check("load_queue_drained", exp_load_q.size(), 0);
        summary();
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
        summary();
        $fatal(1, "bench time limit reached");
    end

endmodule
